vec_addsub_pipe: RTL and testbench

Pipelined, parametrised successor to the combinational segmented adder/subtractor in the vector execution unit. Adds or subtracts two WIDTH-bit vectors lane-wise at SEW 8/16/32/64, with per-element masking, reverse-subtract and, optionally, signed or unsigned saturation. An elastic valid/ready pipeline of STAGES register stages sits between the vector operand-fetch stage and the vector writeback arbiter.

---
 rtl/vec_addsub_pkg.sv | 35 +++
 rtl/vec_addsub_lane64.sv | 99 +++++++++
 rtl/vec_addsub_pipe.sv | 167 ++++++++++++++++
 tb/tb_vec_addsub_pipe.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_addsub_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | vec_addsub_pkg : shared types and helpers for the vector add/sub pipe  |
// | Revision       : 1.0                                                    |
// +------------------------------------------------------------------------+
package vec_addsub_pkg;

  localparam int MIN_SEW = 8;

  typedef enum logic [1:0] {
    SEW_8  = 2'b00,
    SEW_16 = 2'b01,
    SEW_32 = 2'b10,
    SEW_64 = 2'b11
  } sew_e;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_RSUB = 2'b10,
    OP_RSVD = 2'b11
  } addsub_op_e;

  function automatic int unsigned sew_bits(sew_e s);
    case (s)
      SEW_8:   return 8;
      SEW_16:  return 16;
      SEW_32:  return 32;
      SEW_64:  return 64;
      default: return 8;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vec_addsub_lane64.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | vec_addsub_lane64 : 64-bit segmented add/sub slice, SEW 8/16/32/64      |
// | Optional saturation with VEC_ADDSUB_SAT_EN. Revision: 1.0              |
// +------------------------------------------------------------------------+
module vec_addsub_lane64
  import vec_addsub_pkg::*;
(
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  input  logic [7:0]  i_mask,
  input  sew_e        i_sew,
  input  addsub_op_e  i_op,
`ifdef VEC_ADDSUB_SAT_EN
  input  logic        i_sat,
  input  logic        i_sgn,
  output logic [7:0]  o_ovf,
`endif
  output logic [63:0] o_res
);

  logic [2:0]  w_nbm;
  logic        w_sub;
  logic [63:0] w_x;
  logic [63:0] w_y;
  logic [63:0] w_sum;
  logic        w_c;
  logic [2:0]  w_top;
  logic [2:0]  w_start;
`ifdef VEC_ADDSUB_SAT_EN
  logic [7:0]  w_co;
  logic        w_xm;
  logic        w_ym;
  logic        w_sm;
  logic        w_ovf_e;
`endif

  always_comb begin
    w_nbm = 3'((sew_bits(i_sew) / MIN_SEW) - 1);
    w_sub = (i_op == OP_SUB) || (i_op == OP_RSUB);
    w_x   = (i_op == OP_RSUB) ? i_b : i_a;
    w_y   = (i_op == OP_RSUB) ? i_a : i_b;
    if (w_sub) w_y = ~w_y;
  end

  // Byte-wise carry chain, restarted with the subtract carry-in at each element LSB.
  always_comb begin
    w_sum = '0;
    w_c   = 1'b0;
`ifdef VEC_ADDSUB_SAT_EN
    w_co  = '0;
`endif
    for (int k = 0; k < 8; k++) begin
      if ((3'(k) & w_nbm) == 3'd0) w_c = w_sub;
      {w_c, w_sum[k*8 +: 8]} = {1'b0, w_x[k*8 +: 8]} + {1'b0, w_y[k*8 +: 8]} + {8'd0, w_c};
`ifdef VEC_ADDSUB_SAT_EN
      w_co[k] = w_c;
`endif
    end
  end

  always_comb begin
    o_res   = i_a;
    w_top   = '0;
    w_start = '0;
`ifdef VEC_ADDSUB_SAT_EN
    o_ovf   = '0;
    w_xm    = 1'b0;
    w_ym    = 1'b0;
    w_sm    = 1'b0;
    w_ovf_e = 1'b0;
`endif
    for (int k = 0; k < 8; k++) begin
      w_top   = 3'(k) | w_nbm;
      w_start = 3'(k) & ~w_nbm;
      if (i_mask[w_start]) begin
        o_res[k*8 +: 8] = w_sum[k*8 +: 8];
`ifdef VEC_ADDSUB_SAT_EN
        w_xm    = w_x[{w_top, 3'b111}];
        w_ym    = w_y[{w_top, 3'b111}];
        w_sm    = w_sum[{w_top, 3'b111}];
        w_ovf_e = i_sgn ? ((w_xm == w_ym) && (w_sm != w_xm))
                        : (w_sub ? !w_co[w_top] : w_co[w_top]);
        if (i_sat && w_ovf_e) begin
          if (!i_sgn)
            o_res[k*8 +: 8] = w_sub ? 8'h00 : 8'hFF;
          else if (3'(k) == w_top)
            o_res[k*8 +: 8] = w_xm ? 8'h80 : 8'h7F;
          else
            o_res[k*8 +: 8] = w_xm ? 8'h00 : 8'hFF;
          if (3'(k) == w_start) o_ovf[k] = 1'b1;
        end
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vec_addsub_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | vec_addsub_pipe : elastic STAGES-deep lane-wise vector add/sub pipeline |
// | Saturation ports/logic with VEC_ADDSUB_SAT_EN. Revision: 1.0           |
// +------------------------------------------------------------------------+
module vec_addsub_pipe
  import vec_addsub_pkg::*;
#(
  parameter int WIDTH  = 512,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         op,
  input  logic [1:0]         sew,
`ifdef VEC_ADDSUB_SAT_EN
  input  logic               sat,
  input  logic               sgn,
`endif
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH/8-1:0] mask,
  output logic               out_valid,
  input  logic               out_ready,
`ifdef VEC_ADDSUB_SAT_EN
  output logic               out_vxsat,
`endif
  output logic [WIDTH-1:0]   out_data
);

  localparam int NLANE = WIDTH / 64;
  localparam int NBYTE = WIDTH / 8;

  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] w_take;
  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [NBYTE-1:0]  r_mask;
  logic [1:0]        r_op;
  logic [1:0]        r_sew;
  logic [WIDTH-1:0]  w_res;
`ifdef VEC_ADDSUB_SAT_EN
  logic              r_sat;
  logic              r_sgn;
  logic [NBYTE-1:0]  w_ovf;
  logic              w_vxsat;
`endif

  // A stage can take a beat when empty or when it is itself moving on.
  always_comb begin
    w_take = '0;
    w_take[STAGES-1] = !r_vld[STAGES-1] || out_ready;
    for (int s = STAGES - 2; s >= 0; s--) begin
      w_take[s] = !r_vld[s] || w_take[s+1];
    end
  end

  assign in_ready  = w_take[0];
  assign out_valid = r_vld[STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
    end else begin
      if (w_take[0]) r_vld[0] <= in_valid;
      for (int s = 1; s < STAGES; s++) begin
        if (w_take[s]) r_vld[s] <= r_vld[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_mask <= '0;
      r_op   <= '0;
      r_sew  <= '0;
`ifdef VEC_ADDSUB_SAT_EN
      r_sat  <= 1'b0;
      r_sgn  <= 1'b0;
`endif
    end else if (w_take[0] && in_valid) begin
      r_a    <= a;
      r_b    <= b;
      r_mask <= mask;
      r_op   <= op;
      r_sew  <= sew;
`ifdef VEC_ADDSUB_SAT_EN
      r_sat  <= sat;
      r_sgn  <= sgn;
`endif
    end
  end

  generate
    for (genvar g = 0; g < NLANE; g++) begin : g_lane
      vec_addsub_lane64 u_lane (
        .i_a    (r_a[g*64 +: 64]),
        .i_b    (r_b[g*64 +: 64]),
        .i_mask (r_mask[g*8 +: 8]),
        .i_sew  (sew_e'(r_sew)),
        .i_op   (addsub_op_e'(r_op)),
`ifdef VEC_ADDSUB_SAT_EN
        .i_sat  (r_sat),
        .i_sgn  (r_sgn),
        .o_ovf  (w_ovf[g*8 +: 8]),
`endif
        .o_res  (w_res[g*64 +: 64])
      );
    end
  endgenerate

`ifdef VEC_ADDSUB_SAT_EN
  assign w_vxsat = |w_ovf;
`endif

  generate
    if (STAGES == 1) begin : g_direct
      assign out_data = w_res;
`ifdef VEC_ADDSUB_SAT_EN
      assign out_vxsat = w_vxsat;
`endif
    end else begin : g_regs
      // r_data[k] is stage k+1; stage 0 keeps the operands.
      logic [WIDTH-1:0] r_data [STAGES-1];
`ifdef VEC_ADDSUB_SAT_EN
      logic             r_vxs  [STAGES-1];
`endif

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < STAGES - 1; k++) begin
            r_data[k] <= '0;
`ifdef VEC_ADDSUB_SAT_EN
            r_vxs[k]  <= 1'b0;
`endif
          end
        end else begin
          if (w_take[1] && r_vld[0]) begin
            r_data[0] <= w_res;
`ifdef VEC_ADDSUB_SAT_EN
            r_vxs[0]  <= w_vxsat;
`endif
          end
          for (int k = 1; k < STAGES - 1; k++) begin
            if (w_take[k+1] && r_vld[k]) begin
              r_data[k] <= r_data[k-1];
`ifdef VEC_ADDSUB_SAT_EN
              r_vxs[k]  <= r_vxs[k-1];
`endif
            end
          end
        end
      end

      assign out_data = r_data[STAGES-2];
`ifdef VEC_ADDSUB_SAT_EN
      assign out_vxsat = r_vxs[STAGES-2];
`endif
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_vec_addsub_pipe.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_vec_addsub_pipe : self-checking bench for vec_addsub_pipe           |
// | Saturation cases enabled with VEC_ADDSUB_SAT_EN. Revision: 1.0         |
// +------------------------------------------------------------------------+
module tb_vec_addsub_pipe;

  localparam int WIDTH  = 512;
  localparam int STAGES = 2;
  localparam int NB     = WIDTH / 8;

  typedef struct {
    logic [1:0]       op;
    logic [1:0]       sew;
    logic             sat;
    logic             sgn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [NB-1:0]    mask;
    logic [WIDTH-1:0] exp;
    logic             exp_vx;
  } vec_t;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [1:0]       sew;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [NB-1:0]    mask;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef VEC_ADDSUB_SAT_EN
  logic             sat;
  logic             sgn;
  logic             out_vxsat;
`endif

  int checks = 0;
  int errors = 0;

  vec_addsub_pipe #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .sew       (sew),
`ifdef VEC_ADDSUB_SAT_EN
    .sat       (sat),
    .sgn       (sgn),
    .out_vxsat (out_vxsat),
`endif
    .a         (a),
    .b         (b),
    .mask      (mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: per-element integer arithmetic with clamping on the exact result.
  function automatic void model(input vec_t v, output logic [WIDTH-1:0] res, output logic vx);
    int n, ne;
    logic [63:0] ea, eb, emask;
    logic signed [66:0] xv, yv, full, lo, hi;
    n  = 8 << v.sew;
    ne = WIDTH / n;
    res = '0;
    vx  = 1'b0;
    emask = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    for (int e = 0; e < ne; e++) begin
      ea = 64'(v.a >> (e * n)) & emask;
      eb = 64'(v.b >> (e * n)) & emask;
      if (!v.mask[e * n / 8]) begin
        res |= WIDTH'(ea) << (e * n);
      end else begin
        xv = {3'b000, ea};
        yv = {3'b000, eb};
        if (v.sgn && ea[n-1]) xv = xv - (67'sd1 <<< n);
        if (v.sgn && eb[n-1]) yv = yv - (67'sd1 <<< n);
        case (v.op)
          2'b01:   full = xv - yv;
          2'b10:   full = yv - xv;
          default: full = xv + yv;
        endcase
        if (v.sgn) begin
          lo = -(67'sd1 <<< (n - 1));
          hi = (67'sd1 <<< (n - 1)) - 67'sd1;
        end else begin
          lo = '0;
          hi = (67'sd1 <<< n) - 67'sd1;
        end
        if (v.sat && full > hi) begin
          full = hi;
          vx = 1'b1;
        end else if (v.sat && full < lo) begin
          full = lo;
          vx = 1'b1;
        end
        res |= WIDTH'(64'(full) & emask) << (e * n);
      end
    end
  endfunction

  function automatic vec_t mk(input logic [1:0] o, input logic [1:0] s, input logic st, input logic sg,
                              input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                              input logic [NB-1:0] m, input logic [WIDTH-1:0] e, input logic vx);
    vec_t v;
    v.op = o; v.sew = s; v.sat = st; v.sgn = sg;
    v.a = va; v.b = vb; v.mask = m; v.exp = e; v.exp_vx = vx;
    return v;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    v.op  = 2'($urandom_range(0, 3));
    v.sew = 2'($urandom_range(0, 3));
    for (int i = 0; i < WIDTH / 32; i++) begin
      v.a[i*32 +: 32] = $urandom;
      v.b[i*32 +: 32] = $urandom;
    end
    for (int i = 0; i < NB / 32; i++) v.mask[i*32 +: 32] = $urandom;
    case ($urandom_range(0, 3))
      0:       v.b = ~v.a;
      1:       v.b = v.a;
      default: ;
    endcase
`ifdef VEC_ADDSUB_SAT_EN
    v.sat = 1'($urandom_range(0, 1));
    v.sgn = 1'($urandom_range(0, 1));
`else
    v.sat = 1'b0;
    v.sgn = 1'b0;
`endif
    model(v, v.exp, v.exp_vx);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    op   = v.op;
    sew  = v.sew;
    a    = v.a;
    b    = v.b;
    mask = v.mask;
`ifdef VEC_ADDSUB_SAT_EN
    sat  = v.sat;
    sgn  = v.sgn;
`endif
  endtask

  task automatic run_single(input vec_t v, input string name);
    int lat;
    @(posedge clk); #1;
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    chk({name, "_in_ready"}, WIDTH'(in_ready), WIDTH'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk({name, "_latency"}, WIDTH'(lat), WIDTH'(STAGES));
    chk({name, "_data"}, out_data, v.exp);
`ifdef VEC_ADDSUB_SAT_EN
    chk({name, "_vxsat"}, WIDTH'(out_vxsat), WIDTH'(v.exp_vx));
`endif
  endtask

  vec_t tbl[$];
  vec_t bp[6];
  vec_t q[$];
  vec_t cur;
  vec_t exp_v;

  initial begin
    logic acc;
    logic pop;
    int idx, got, cyc_cnt, seen;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; sew = '0; a = '0; b = '0; mask = '0;
`ifdef VEC_ADDSUB_SAT_EN
    sat = 1'b0; sgn = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", WIDTH'(out_valid), '0);
    chk("reset_out_data", out_data, '0);
    chk("reset_in_ready", WIDTH'(in_ready), WIDTH'(1));
`ifdef VEC_ADDSUB_SAT_EN
    chk("reset_out_vxsat", WIDTH'(out_vxsat), '0);
`endif

    tbl.push_back(mk(2'b00, 2'b00, 0, 0, {64{8'hF7}}, {64{8'h12}}, '1, {64{8'h09}}, 0));
    tbl.push_back(mk(2'b01, 2'b11, 0, 0, {8{64'h0}}, {8{64'h1}}, '1, {8{64'hFFFF_FFFF_FFFF_FFFF}}, 0));
    tbl.push_back(mk(2'b10, 2'b01, 0, 0, {32{16'h0001}}, {32{16'h0005}}, {16{4'b0001}}, {16{32'h0001_0004}}, 0));
    tbl.push_back(mk(2'b11, 2'b10, 0, 0, {16{32'h5}}, {16{32'h3}}, '1, {16{32'h8}}, 0));
    tbl.push_back(mk(2'b01, 2'b00, 0, 0, {64{8'h5A}}, {64{8'h33}}, '0, {64{8'h5A}}, 0));
    tbl.push_back(mk(2'b00, 2'b01, 0, 0, {32{16'hFFFF}}, {32{16'h0001}}, '1, '0, 0));
    tbl.push_back(mk(2'b01, 2'b10, 0, 0, {16{32'h1234_5678}}, {16{32'h1}}, {16{4'b1110}}, {16{32'h1234_5678}}, 0));
`ifdef VEC_ADDSUB_SAT_EN
    tbl.push_back(mk(2'b00, 2'b10, 1, 1, {16{32'h7FFF_FFFF}}, {16{32'h1}}, '1, {16{32'h7FFF_FFFF}}, 1));
    tbl.push_back(mk(2'b01, 2'b10, 1, 0, '0, {16{32'h1}}, '1, '0, 1));
    tbl.push_back(mk(2'b00, 2'b00, 1, 0, {64{8'hFF}}, {64{8'h01}}, '1, {64{8'hFF}}, 1));
    tbl.push_back(mk(2'b01, 2'b01, 1, 1, {32{16'h8000}}, {32{16'h0001}}, '1, {32{16'h8000}}, 1));
    tbl.push_back(mk(2'b00, 2'b00, 1, 1, {64{8'h10}}, {64{8'h20}}, '1, {64{8'h30}}, 0));
`endif
    foreach (tbl[i]) run_single(tbl[i], $sformatf("vec%0d", i));

    // Backpressure: fill with out_ready low, then release and drain in order.
    for (int j = 0; j < 6; j++)
      bp[j] = mk(2'b00, 2'b11, 0, 0, {8{64'(j + 1)}}, '0, '1, {8{64'(j + 1)}}, 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      drive(bp[idx]);
      in_valid = 1'b1;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) idx++;
    end
    @(negedge clk);
    chk("bp_accepted", WIDTH'(idx), WIDTH'(STAGES));
    chk("bp_in_ready_low", WIDTH'(in_ready), '0);
    chk("bp_out_valid_held", WIDTH'(out_valid), WIDTH'(1));
    @(posedge clk); #1;
    out_ready = 1'b1;
    got = 0;
    cyc_cnt = 0;
    while (got < 6 && cyc_cnt < 20) begin
      if (idx < 6) begin
        drive(bp[idx]);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      pop = out_valid;
      if (pop) chk($sformatf("bp_order%0d", got), out_data, bp[got].exp);
      @(posedge clk); #1;
      if (acc) idx++;
      if (pop) got++;
      cyc_cnt++;
    end
    in_valid = 1'b0;
    chk("bp_results", WIDTH'(got), WIDTH'(6));
    chk("bp_drain_cycles", WIDTH'(cyc_cnt), WIDTH'(6));
    @(negedge clk);
    chk("bp_no_extra", WIDTH'(out_valid), '0);

    // Randomised traffic with random backpressure against the reference model.
    cur = rand_vec();
    acc = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      if (acc) cur = rand_vec();
      drive(cur);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rand_spurious: got out_valid=1, expected no beat in flight");
        end else begin
          exp_v = q.pop_front();
          chk("rand_data", out_data, exp_v.exp);
`ifdef VEC_ADDSUB_SAT_EN
          chk("rand_vxsat", WIDTH'(out_vxsat), WIDTH'(exp_v.exp_vx));
`endif
        end
      end
      acc = in_valid && in_ready;
      if (acc) q.push_back(cur);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      @(negedge clk);
      if (out_valid) begin
        exp_v = q.pop_front();
        chk("drain_data", out_data, exp_v.exp);
      end
      @(posedge clk); #1;
    end
    chk("drain_empty", WIDTH'(q.size()), '0);

    // Reset with beats in flight drops them.
    out_ready = 1'b0;
    drive(bp[4]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    drive(bp[5]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", WIDTH'(out_valid), '0);
    chk("rst_mid_out_data", out_data, '0);
    chk("rst_mid_in_ready", WIDTH'(in_ready), WIDTH'(1));
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_mid_dropped", WIDTH'(seen), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, expected finish before time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
